trigger_hls_deadlock_reporter: RTL and testbench

Consumes the `block` / `axis_block_info` outputs of the trigger HLS deadlock monitor. Qualifies them into a sticky, software-visible deadlock status. A stall is declared only after `block` stays high for a programmable number of consecutive cycles. On declaration the block latches the blocked AXIS channels, pulses an interrupt and keeps stall statistics for debug readout over the control interface.

---
 rtl/trigger_deadlock_pkg.sv | 25 ++
 rtl/trigger_sat_counter.sv | 31 +++
 rtl/trigger_hls_deadlock_reporter.sv | 142 ++++++++++++++
 tb/tb_trigger_hls_deadlock_reporter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trigger_deadlock_pkg.sv
// Shared types and helpers for the trigger HLS deadlock reporter: FSM state
// encoding, default widths and a saturating increment.
package trigger_deadlock_pkg;

  localparam int DEF_INFO_W = 4;
  localparam int DEF_CNT_W  = 16;
  localparam int DEF_EVT_W  = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WATCH    = 2'd1,
    DETECTED = 2'd2
  } state_t;

  // Callers zero-extend into 32 bits and truncate the result back to their width.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    if (value >= max_value) begin
      return max_value;
    end else begin
      return value + 32'd1;
    end
  endfunction

endpackage

// File: rtl/trigger_sat_counter.sv
// Parameterised saturating up-counter with synchronous clear and increment enable.
module trigger_sat_counter
  import trigger_deadlock_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // Counter register; clear outranks increment.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= {W{1'b0}};
    end else if (clr) begin
      count_r <= {W{1'b0}};
    end else if (inc) begin
      count_r <= W'(sat_inc(32'(count_r), 32'({W{1'b1}})));
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/trigger_hls_deadlock_reporter.sv
// Qualifies the HLS deadlock monitor's block flag into a sticky deadlock status
// with a one-cycle irq, latched channel info and stall statistics.
module trigger_hls_deadlock_reporter
  import trigger_deadlock_pkg::*;
#(
  parameter int INFO_W = DEF_INFO_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int EVT_W  = DEF_EVT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [CNT_W-1:0]  threshold,
  input  logic              clear,
  input  logic              block,
  input  logic [INFO_W-1:0] axis_block_info,
  output logic              deadlock,
  output logic              irq,
  output logic [INFO_W-1:0] latched_info,
  output logic [CNT_W-1:0]  run_len,
  output logic [CNT_W-1:0]  max_stall,
  output logic [EVT_W-1:0]  event_count
);

  state_t             state_r, state_next_s;
  logic [CNT_W-1:0]   eff_thr_s, run_len_s, run_len_inc_s, run_len_next_s, max_stall_r;
  logic               run_clr_s, run_inc_s, detect_s;
  logic               deadlock_r, irq_r;
  logic [INFO_W-1:0]  latched_info_r;

  // A programmed threshold of 0 behaves like 1.
  assign eff_thr_s     = (threshold == {CNT_W{1'b0}}) ? CNT_W'(1) : threshold;
  assign run_len_inc_s = CNT_W'(sat_inc(32'(run_len_s), 32'({CNT_W{1'b1}})));

  // Next state and run-length counter control; IDLE always holds run_len at 0.
  always_comb begin
    state_next_s = state_r;
    run_clr_s    = 1'b0;
    run_inc_s    = 1'b0;
    detect_s     = 1'b0;
    if (clear) begin
      state_next_s = IDLE;
      run_clr_s    = 1'b1;
    end else begin
      case (state_r)
        IDLE, WATCH: begin
          if (enable && block) begin
            run_inc_s = 1'b1;
            if (run_len_inc_s == eff_thr_s) begin
              state_next_s = DETECTED;
              detect_s     = 1'b1;
            end else begin
              state_next_s = WATCH;
            end
          end else begin
            state_next_s = IDLE;
            run_clr_s    = 1'b1;
          end
        end
        DETECTED: begin
          if (block) begin
            run_inc_s = 1'b1;
          end else begin
            run_inc_s = 1'b0;
          end
        end
        default: begin
          state_next_s = IDLE;
          run_clr_s    = 1'b1;
        end
      endcase
    end
  end

  // Value run_len takes at the next edge, for the max_stall comparison.
  always_comb begin
    if (run_clr_s) begin
      run_len_next_s = {CNT_W{1'b0}};
    end else if (run_inc_s) begin
      run_len_next_s = run_len_inc_s;
    end else begin
      run_len_next_s = run_len_s;
    end
  end

  // State, sticky status, info latch and max_stall registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r        <= IDLE;
      deadlock_r     <= 1'b0;
      irq_r          <= 1'b0;
      latched_info_r <= {INFO_W{1'b0}};
      max_stall_r    <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      irq_r   <= detect_s;
      if (clear) begin
        deadlock_r     <= 1'b0;
        latched_info_r <= {INFO_W{1'b0}};
        max_stall_r    <= {CNT_W{1'b0}};
      end else begin
        if (detect_s) begin
          deadlock_r     <= 1'b1;
          latched_info_r <= axis_block_info;
        end else if (state_r == DETECTED) begin
          latched_info_r <= latched_info_r | axis_block_info;
        end else begin
          latched_info_r <= latched_info_r;
        end
        if (run_len_next_s > max_stall_r) begin
          max_stall_r <= run_len_next_s;
        end else begin
          max_stall_r <= max_stall_r;
        end
      end
    end
  end

  trigger_sat_counter #(.W(CNT_W)) u_run_len (
    .clock (clock),
    .reset (reset),
    .clr   (run_clr_s),
    .inc   (run_inc_s),
    .count (run_len_s)
  );

  // Event count survives clear; only reset zeroes it.
  trigger_sat_counter #(.W(EVT_W)) u_event_count (
    .clock (clock),
    .reset (reset),
    .clr   (1'b0),
    .inc   (detect_s),
    .count (event_count)
  );

  assign deadlock     = deadlock_r;
  assign irq          = irq_r;
  assign latched_info = latched_info_r;
  assign run_len      = run_len_s;
  assign max_stall    = max_stall_r;

endmodule

// File: tb/tb_trigger_hls_deadlock_reporter.sv
// Bench for the deadlock reporter: a default-width instance and a narrow
// (CNT_W=4, EVT_W=2) instance share stimulus and are checked against a reference model.
module tb_trigger_hls_deadlock_reporter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable, clear, block;
  logic [15:0] threshold;
  logic [3:0]  info;

  logic        dl0, irq0, dl1, irq1;
  logic [3:0]  li0, li1;
  logic [15:0] rl0, ms0;
  logic [3:0]  rl1, ms1;
  logic [7:0]  ev0;
  logic [1:0]  ev1;

  int tests = 0;
  int fails = 0;

  int m_run[2], m_max[2], m_evt[2], m_info[2];
  bit m_det[2], m_irq[2];
  int cmax[2] = '{65535, 15};
  int emax[2] = '{255, 3};

  always #5 clock = ~clock;

  trigger_hls_deadlock_reporter u_dut (
    .clock(clock), .reset(reset), .enable(enable), .threshold(threshold),
    .clear(clear), .block(block), .axis_block_info(info),
    .deadlock(dl0), .irq(irq0), .latched_info(li0), .run_len(rl0),
    .max_stall(ms0), .event_count(ev0)
  );

  trigger_hls_deadlock_reporter #(.INFO_W(4), .CNT_W(4), .EVT_W(2)) u_small (
    .clock(clock), .reset(reset), .enable(enable), .threshold(threshold[3:0]),
    .clear(clear), .block(block), .axis_block_info(info),
    .deadlock(dl1), .irq(irq1), .latched_info(li1), .run_len(rl1),
    .max_stall(ms1), .event_count(ev1)
  );

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0; m_max[k] = 0; m_evt[k] = 0; m_info[k] = 0;
      m_det[k] = 1'b0; m_irq[k] = 1'b0;
    end
  endtask

  // One clock edge of the behavioural model, using the inputs as seen at that edge.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int thr, eff;
      thr = (k == 0) ? int'(threshold) : int'(threshold[3:0]);
      eff = (thr == 0) ? 1 : thr;
      if (clear) begin
        m_det[k] = 1'b0; m_run[k] = 0; m_info[k] = 0; m_max[k] = 0; m_irq[k] = 1'b0;
      end else begin
        m_irq[k] = 1'b0;
        if (m_det[k]) begin
          if (block) m_run[k] = (m_run[k] + 1 > cmax[k]) ? cmax[k] : m_run[k] + 1;
          m_info[k] = m_info[k] | int'(info);
        end else if (enable && block) begin
          m_run[k] = (m_run[k] + 1 > cmax[k]) ? cmax[k] : m_run[k] + 1;
          if (m_run[k] == eff) begin
            m_det[k]  = 1'b1;
            m_irq[k]  = 1'b1;
            m_info[k] = int'(info);
            m_evt[k]  = (m_evt[k] + 1 > emax[k]) ? emax[k] : m_evt[k] + 1;
          end
        end else begin
          m_run[k] = 0;
        end
        if (m_run[k] > m_max[k]) m_max[k] = m_run[k];
      end
    end
  endtask

  task automatic check_all();
    cmp("dut.deadlock",    32'(dl0),  32'(m_det[0]));
    cmp("dut.irq",         32'(irq0), 32'(m_irq[0]));
    cmp("dut.latched",     32'(li0),  32'(m_info[0]));
    cmp("dut.run_len",     32'(rl0),  32'(m_run[0]));
    cmp("dut.max_stall",   32'(ms0),  32'(m_max[0]));
    cmp("dut.event_count", 32'(ev0),  32'(m_evt[0]));
    cmp("sml.deadlock",    32'(dl1),  32'(m_det[1]));
    cmp("sml.irq",         32'(irq1), 32'(m_irq[1]));
    cmp("sml.latched",     32'(li1),  32'(m_info[1]));
    cmp("sml.run_len",     32'(rl1),  32'(m_run[1]));
    cmp("sml.max_stall",   32'(ms1),  32'(m_max[1]));
    cmp("sml.event_count", 32'(ev1),  32'(m_evt[1]));
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_all();
  endtask

  task automatic async_reset_check(input string tag);
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    cmp({tag, ".deadlock"}, 32'(dl0), 32'd0);
    cmp({tag, ".event"},    32'(ev0), 32'd0);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    enable = 1'b0; clear = 1'b0; block = 1'b0; info = 4'd0; threshold = 16'd4;
    model_reset();
    repeat (2) @(negedge clock);
    check_all();
    reset = 1'b0;

    // Basic detection at threshold 4
    enable = 1'b1; block = 1'b1; info = 4'b1110;
    repeat (4) tick();
    cmp("basic.deadlock", 32'(dl0), 32'd1);
    cmp("basic.irq",      32'(irq0), 32'd1);
    tick();
    cmp("basic.irq_low",  32'(irq0), 32'd0);
    tick();
    cmp("basic.run_len",  32'(rl0), 32'd6);
    cmp("basic.latched",  32'(li0), 32'b1110);
    cmp("basic.event",    32'(ev0), 32'd1);
    block = 1'b0; info = 4'd0;
    tick();
    cmp("basic.run_hold", 32'(rl0), 32'd6);

    // Info accumulation, then clear with block held
    block = 1'b1; info = 4'b1011;
    tick();
    cmp("accum.latched", 32'(li0), 32'b1111);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    cmp("clear.deadlock", 32'(dl0), 32'd0);
    cmp("clear.max",      32'(ms0), 32'd0);
    repeat (3) tick();
    cmp("reclear.early", 32'(dl0), 32'd0);
    tick();
    cmp("reclear.deadlock", 32'(dl0), 32'd1);
    cmp("reclear.event",    32'(ev0), 32'd2);

    // Sub-threshold runs with a single-cycle dropout
    block = 1'b0; info = 4'd0; clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 8; i++) begin
      block = (i != 3 && i != 7);
      info  = block ? 4'b0011 : 4'd0;
      tick();
    end
    cmp("sub.deadlock", 32'(dl0), 32'd0);
    cmp("sub.max",      32'(ms0), 32'd3);

    // Threshold 0 detects on the first blocked edge
    enable = 1'b0; block = 1'b0; info = 4'd0;
    tick();
    threshold = 16'd0; enable = 1'b1; block = 1'b1; info = 4'b0101;
    tick();
    cmp("thr0.deadlock", 32'(dl0), 32'd1);
    cmp("thr0.irq",      32'(irq0), 32'd1);

    // Clear coincident with the detecting edge
    block = 1'b0; info = 4'd0; clear = 1'b1;
    tick();
    clear = 1'b0; enable = 1'b0;
    tick();
    threshold = 16'd3; enable = 1'b1; block = 1'b1; info = 4'b0010;
    repeat (2) tick();
    clear = 1'b1;
    tick();
    cmp("coinc.irq",   32'(irq0), 32'd0);
    cmp("coinc.event", 32'(ev0),  32'd3);
    clear = 1'b0; block = 1'b0; info = 4'd0;
    tick();

    // Saturation of run_len/max_stall (narrow) and event_count (narrow)
    enable = 1'b0;
    tick();
    threshold = 16'd15; clear = 1'b1;
    tick();
    clear = 1'b0; enable = 1'b1; block = 1'b1; info = 4'b0100;
    repeat (20) tick();
    cmp("sat.run_small", 32'(rl1), 32'd15);
    cmp("sat.max_small", 32'(ms1), 32'd15);
    cmp("sat.run_big",   32'(rl0), 32'd20);
    block = 1'b0; info = 4'd0; clear = 1'b1; enable = 1'b0;
    tick();
    clear = 1'b0; threshold = 16'd1; enable = 1'b1; block = 1'b1; info = 4'b1000;
    tick();
    cmp("sat.event_big",   32'(ev0), 32'd5);
    cmp("sat.event_small", 32'(ev1), 32'd3);

    // Enable low keeps the block idle
    block = 1'b0; info = 4'd0; clear = 1'b1;
    tick();
    clear = 1'b0; enable = 1'b0; block = 1'b1; info = 4'b0001;
    repeat (5) tick();
    cmp("dis.deadlock", 32'(dl0), 32'd0);
    cmp("dis.run_len",  32'(rl0), 32'd0);

    // Asynchronous reset mid-WATCH and mid-DETECTED
    threshold = 16'd10; enable = 1'b1;
    repeat (3) tick();
    async_reset_check("rst_watch");
    enable = 1'b0; block = 1'b0; info = 4'd0;
    tick();
    threshold = 16'd2; enable = 1'b1; block = 1'b1; info = 4'b0110;
    repeat (3) tick();
    cmp("rst_det.pre", 32'(dl0), 32'd1);
    async_reset_check("rst_det");

    // Randomised traffic; threshold only changes while disabled
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      if (!enable && $urandom_range(0, 1) == 0) threshold = 16'($urandom_range(0, 6));
      block = ($urandom_range(0, 3) != 0);
      info  = block ? 4'($urandom_range(1, 15)) : 4'd0;
      clear = ($urandom_range(0, 29) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
